lsu_mem_ctrl: RTL

//  Memory-stage load/store sequencer: takes one access per M-stage instruction, drives a req/gnt/rvalid

---
 rtl/lsu_pkg.sv | 70 +++++++
 rtl/lsu_load_align.sv | 29 ++
 rtl/lsu_mem_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store sequencer.
// Optional feature macro: MISALIGN_TRAP_EN (adds misalignment detection helper).
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } lsu_state_e;

  // RV32I load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  // RV32I store funct3 encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Byte enables for a store of the given size at byte offset a.
  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] a);
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << {a[1], 1'b0};
      default: be = 4'hF;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane the access may land in.
  function automatic logic [31:0] store_rep(input logic [2:0] funct3, input logic [31:0] d);
    logic [31:0] w;
    case (funct3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // funct3 legality: stores only SB/SH/SW; loads LB/LH/LW/LBU/LHU.
  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    logic ok;
    if (we) begin
      ok = (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
    end else begin
      ok = (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
           (funct3 == LBU) || (funct3 == LHU);
    end
    return ok;
  endfunction

`ifdef MISALIGN_TRAP_EN
  // Halfwords must be 2-byte aligned, words 4-byte aligned.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] a);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = a[0];
      2'b10:   mis = (a != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction
`endif

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: selects byte/half/word from the captured
// bus word by address offset and sign- or zero-extends it per funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  // Shift the addressed lane down to bit 0, then extend by access size/signedness
  always_comb begin
    byte_sh = word_i >> {addr_lo_i, 3'b000};
    half_sh = word_i >> {addr_lo_i[1], 4'b0000};
    case (funct3_i)
      LB:      data_o = {{24{byte_sh[7]}}, byte_sh[7:0]};
      LBU:     data_o = {24'h0, byte_sh[7:0]};
      LH:      data_o = {{16{half_sh[15]}}, half_sh[15:0]};
      LHU:     data_o = {16'h0, half_sh[15:0]};
      LW:      data_o = word_i;
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Memory-stage load/store sequencer. Accepts one access per M-stage
// instruction, runs it over a req/gnt/rvalid bus while stalling the pipe,
// and returns a one-cycle done pulse with error flag and extended load data.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word accesses
// complete with err_o and no bus access instead of ignoring low address bits).
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic              err_o,
  output logic [XLEN-1:0]   ld_data_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i
);

  generate
    if (XLEN != 32) begin : g_bad_xlen
      $error("lsu_mem_ctrl: XLEN must be 32");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
      $error("lsu_mem_ctrl: TIMEOUT must be >= 2");
    end
  endgenerate

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            access_ok;
  logic            timeout;
  logic [31:0]     ld_aligned;

`ifdef MISALIGN_TRAP_EN
  assign access_ok = funct3_legal(req_we_i, req_funct3_i) &
                     ~misaligned(req_funct3_i, req_addr_i[1:0]);
`else
  assign access_ok = funct3_legal(req_we_i, req_funct3_i);
`endif

  assign timeout = (cnt_q == CNT_LAST);

  // State, counter, error flag and captured read word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Request fields are frozen on leaving IDLE so the pipe may change them freely
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else if (state_q == IDLE && req_valid_i) begin
      we_q    <= req_we_i;
      f3_q    <= req_funct3_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
    end
  end

  // Next-state logic; rvalid is only honoured in WAIT_R
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (access_ok) begin
            state_d = REQ;
            cnt_d   = '0;
            err_d   = 1'b0;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (dmem_gnt_i) begin
          if (we_q) begin
            state_d = DONE;
            err_d   = 1'b0;
          end else begin
            state_d = WAIT_R;
            cnt_d   = '0;
          end
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      WAIT_R: begin
        cnt_d = cnt_q + 1'b1;
        if (dmem_rvalid_i) begin
          rdata_d = dmem_rdata_i;
          state_d = DONE;
          err_d   = 1'b0;
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  lsu_load_align u_align (
    .funct3_i  (f3_q),
    .addr_lo_i (addr_q[1:0]),
    .word_i    (rdata_q),
    .data_o    (ld_aligned)
  );

  // Outputs decoded from state; bus fields only driven while requesting
  always_comb begin
    stall_o      = req_valid_i & (state_q != DONE);
    done_o       = 1'b0;
    err_o        = 1'b0;
    ld_data_o    = '0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_be_o    = '0;
    dmem_wdata_o = '0;
    case (state_q)
      REQ: begin
        dmem_req_o   = 1'b1;
        dmem_we_o    = we_q;
        dmem_addr_o  = {addr_q[31:2], 2'b00};
        dmem_be_o    = we_q ? be_gen(f3_q, addr_q[1:0]) : 4'hF;
        dmem_wdata_o = we_q ? store_rep(f3_q, wdata_q) : 32'h0;
      end
      DONE: begin
        done_o    = 1'b1;
        err_o     = err_q;
        ld_data_o = (!err_q && !we_q) ? ld_aligned : 32'h0;
      end
      default: begin
      end
    endcase
  end

endmodule
